l1_trigger_event_formatter: RTL and testbench



---
 rtl/l1_trigger_event_formatter.sv | 211 +++++++++++++++++++++
 tb/tb_l1_trigger_event_formatter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_trigger_event_formatter.sv
// l1_trigger_event_formatter
// Post-processes the raw per-beam L1 trigger bitmap. Each beam is masked and
// subjected to a programmable holdoff, then drives two outputs:
//   * a pulse-stretched bitmap on the DAC stream, packed 12 bits per 16-bit lane
//   * timestamped event records through a first-word-fall-through FIFO with a
//     saturating count of dropped records
module l1_trigger_event_formatter #(
    parameter int NBEAMS     = 2,
    parameter int STRETCH    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NBEAMS-1:0]             trig_i,
    input  logic [NBEAMS-1:0]             mask_i,
    input  logic [15:0]                   holdoff_i,
    output logic [127:0]                  dac_tdata,
    output logic                          dac_tvalid,
    output logic [127:0]                  evt_tdata,
    output logic                          evt_tvalid,
    input  logic                          evt_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [15:0]                   overflow_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Depth and stretch length as sized constants so every compare and load
    // is width-exact.
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       STRETCH_C = 8'(STRETCH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]       r_ts;
    logic [15:0]       r_hold_cnt [NBEAMS];
    logic [7:0]        r_str_cnt  [NBEAMS];
    logic [NBEAMS-1:0] r_fire;
    logic [31:0]       r_fire_ts;
    logic [NBEAMS-1:0] r_sbits;
    logic              r_dac_valid;

    logic [127:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [15:0]       r_ovf_cnt;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [NBEAMS-1:0] w_fire_next;
    logic [95:0]       w_fire96;
    logic [95:0]       w_sbits96;
    logic [127:0]      w_dac_word;
    logic [127:0]      w_record;
    logic              w_valid;
    logic              w_push_req;
    logic              w_pop;
    logic              w_push_ok;

    // Fire decision: raw trigger, not masked, and the beam's holdoff has expired.
    always_comb begin
        w_fire_next = {NBEAMS{1'b0}};
        for (int b = 0; b < NBEAMS; b++) begin
            if ((r_hold_cnt[b] == 16'd0) && trig_i[b] && !mask_i[b]) begin
                w_fire_next[b] = 1'b1;
            end else begin
                w_fire_next[b] = 1'b0;
            end
        end
    end

    // Free-running 32-bit timestamp; wraps naturally at 2^32.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ts <= 32'd0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    // Per-beam holdoff and stretch counters: a fire reloads both (a retrigger
    // restarts the stretch rather than extending it), otherwise each counts
    // down to zero and stays there.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int b = 0; b < NBEAMS; b++) begin
                r_hold_cnt[b] <= 16'd0;
                r_str_cnt[b]  <= 8'd0;
            end
        end else begin
            for (int b = 0; b < NBEAMS; b++) begin
                if (w_fire_next[b]) begin
                    r_hold_cnt[b] <= holdoff_i;
                    r_str_cnt[b]  <= STRETCH_C;
                end else begin
                    if (r_hold_cnt[b] != 16'd0) begin
                        r_hold_cnt[b] <= r_hold_cnt[b] - 16'd1;
                    end
                    if (r_str_cnt[b] != 8'd0) begin
                        r_str_cnt[b] <= r_str_cnt[b] - 8'd1;
                    end
                end
            end
        end
    end

    // Register the fire vector with the timestamp of the sampling edge, the
    // stretched DAC bits, and the DAC valid flag (high from the first edge).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_fire      <= {NBEAMS{1'b0}};
            r_fire_ts   <= 32'd0;
            r_sbits     <= {NBEAMS{1'b0}};
            r_dac_valid <= 1'b0;
        end else begin
            r_fire      <= w_fire_next;
            r_fire_ts   <= r_ts;
            r_dac_valid <= 1'b1;
            for (int b = 0; b < NBEAMS; b++) begin
                r_sbits[b] <= (r_str_cnt[b] != 8'd0);
            end
        end
    end

    // Zero-extend the fire and stretch bitmaps to the fixed 96-bit field.
    always_comb begin
        w_fire96  = 96'd0;
        w_sbits96 = 96'd0;
        for (int b = 0; b < NBEAMS; b++) begin
            w_fire96[b]  = r_fire[b];
            w_sbits96[b] = r_sbits[b];
        end
    end

    // 12-in-16 packing: each 16-bit DAC lane carries 12 bitmap bits in its
    // upper bits with the low nibble held at zero.
    always_comb begin
        w_dac_word = 128'd0;
        for (int i = 0; i < 8; i++) begin
            w_dac_word[16*i +: 4]   = 4'd0;
            w_dac_word[16*i+4 +: 12] = w_sbits96[12*i +: 12];
        end
    end

    // Record layout and FIFO handshake. A full FIFO still accepts a push when
    // a pop retires the head on the same edge; an empty FIFO never pops.
    always_comb begin
        w_record   = {r_fire_ts, w_fire96};
        w_valid    = (r_count != {CNT_W{1'b0}});
        w_push_req = |r_fire;
        w_pop      = w_valid & evt_tready;
        if (w_push_req && ((r_count < DEPTH_C) || w_pop)) begin
            w_push_ok = 1'b1;
        end else begin
            w_push_ok = 1'b0;
        end
    end

    // Event storage; contents are qualified by the occupancy count, so the
    // array itself carries no reset.
    always_ff @(posedge aclk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_record;
        end
    end

    // FIFO pointers, exact occupancy count and saturating drop counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_ovf_cnt <= 16'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push_ok && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    // Output drive. The head word is forced to zero while empty so the data
    // bus reads zero during and right after reset.
    always_comb begin
        dac_tdata        = w_dac_word;
        dac_tvalid       = r_dac_valid;
        evt_tvalid       = w_valid;
        fifo_count_o     = r_count;
        overflow_count_o = r_ovf_cnt;
        if (w_valid) begin
            evt_tdata = r_mem[r_rd_ptr];
        end else begin
            evt_tdata = 128'd0;
        end
    end

endmodule

// File: tb/tb_l1_trigger_event_formatter.sv
// Testbench for l1_trigger_event_formatter (NBEAMS=2, STRETCH=4, FIFO_DEPTH=16).
// Expected event records are queued as triggers are driven and compared as the
// DUT hands them over; DAC and status outputs are checked inline per scenario.
module tb_l1_trigger_event_formatter;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [1:0]   trig_i = 2'b00;
    logic [1:0]   mask_i = 2'b00;
    logic [15:0]  holdoff_i = 16'd0;
    logic         evt_tready = 1'b0;
    logic [127:0] dac_tdata;
    logic         dac_tvalid;
    logic [127:0] evt_tdata;
    logic         evt_tvalid;
    logic [4:0]   fifo_count_o;
    logic [15:0]  overflow_count_o;

    int n_pass = 0;
    int n_total = 0;

    logic [127:0] sb[$];
    logic [31:0]  tb_ts;

    l1_trigger_event_formatter #(
        .NBEAMS(2), .STRETCH(4), .FIFO_DEPTH(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .trig_i(trig_i), .mask_i(mask_i),
        .holdoff_i(holdoff_i), .dac_tdata(dac_tdata), .dac_tvalid(dac_tvalid),
        .evt_tdata(evt_tdata), .evt_tvalid(evt_tvalid), .evt_tready(evt_tready),
        .fifo_count_o(fifo_count_o), .overflow_count_o(overflow_count_o)
    );

    always #5 aclk = ~aclk;

    // Reference timestamp: value the DUT counter holds between edges.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) tb_ts <= 32'd0;
        else          tb_ts <= tb_ts + 32'd1;
    end

    // Scoreboard: every accepted handshake must match the oldest expected record.
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && evt_tvalid === 1'b1 && evt_tready === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL evt_unexpected got %h exp none", evt_tdata);
            end else begin
                logic [127:0] e;
                e = sb.pop_front();
                if (evt_tdata !== e) $display("FAIL evt_record got %h exp %h", evt_tdata, e);
                else n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge aclk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #17;
        n_total++; if (dac_tdata !== 128'd0) $display("FAIL reset_dac_tdata got %h exp 0", dac_tdata); else n_pass++;
        n_total++; if (dac_tvalid !== 1'b0) $display("FAIL reset_dac_tvalid got %b exp 0", dac_tvalid); else n_pass++;
        n_total++; if (evt_tdata !== 128'd0) $display("FAIL reset_evt_tdata got %h exp 0", evt_tdata); else n_pass++;
        n_total++; if (evt_tvalid !== 1'b0) $display("FAIL reset_evt_tvalid got %b exp 0", evt_tvalid); else n_pass++;
        n_total++; if (fifo_count_o !== 5'd0) $display("FAIL reset_fifo_count got %0d exp 0", fifo_count_o); else n_pass++;
        n_total++; if (overflow_count_o !== 16'd0) $display("FAIL reset_overflow got %0d exp 0", overflow_count_o); else n_pass++;
        next_cycle();
        aresetn = 1'b1;
        @(negedge aclk);
        n_total++; if (dac_tvalid !== 1'b0) $display("FAIL dac_tvalid_pre_edge got %b exp 0", dac_tvalid); else n_pass++;
        @(negedge aclk);
        n_total++; if (dac_tvalid !== 1'b1) $display("FAIL dac_tvalid_first_edge got %b exp 1", dac_tvalid); else n_pass++;
    endtask

    task automatic test_single();
        logic [127:0] exp_dac;
        holdoff_i = 16'd0; mask_i = 2'b00; evt_tready = 1'b1;
        for (int g = 0; g < 50 && tb_ts != 32'd10; g++) next_cycle();
        trig_i = 2'b01;
        sb.push_back({tb_ts, 96'h1});
        next_cycle();
        trig_i = 2'b00;
        for (int k = 0; k < 7; k++) begin
            @(negedge aclk);
            exp_dac = (k >= 1 && k <= 4) ? 128'h10 : 128'h0;
            n_total++; if (dac_tdata !== exp_dac) $display("FAIL single_dac k=%0d got %h exp %h", k, dac_tdata, exp_dac); else n_pass++;
            if (k == 1) begin
                n_total++; if (evt_tvalid !== 1'b1) $display("FAIL single_tvalid got %b exp 1", evt_tvalid); else n_pass++;
                n_total++; if (fifo_count_o !== 5'd1) $display("FAIL single_count got %0d exp 1", fifo_count_o); else n_pass++;
            end
        end
        idle(3);
        n_total++; if (sb.size() != 0) $display("FAIL single_pending got %0d exp 0", sb.size()); else n_pass++;
    endtask

    task automatic test_holdoff();
        logic [31:0]  t0;
        logic [127:0] exp_dac;
        holdoff_i = 16'd3; evt_tready = 1'b1;
        next_cycle();
        t0 = tb_ts;
        trig_i = 2'b10;
        sb.push_back({t0, 96'h2});
        sb.push_back({t0 + 32'd4, 96'h2});
        sb.push_back({t0 + 32'd8, 96'h2});
        for (int k = 0; k < 15; k++) begin
            @(posedge aclk);
            #2;
            if (k == 9) trig_i = 2'b00;
            @(negedge aclk);
            exp_dac = (k >= 1 && k <= 12) ? 128'h20 : 128'h0;
            n_total++; if (dac_tdata !== exp_dac) $display("FAIL holdoff_dac k=%0d got %h exp %h", k, dac_tdata, exp_dac); else n_pass++;
        end
        holdoff_i = 16'd0;
        idle(3);
        n_total++; if (sb.size() != 0) $display("FAIL holdoff_pending got %0d exp 0", sb.size()); else n_pass++;
    endtask

    task automatic test_mask();
        logic [127:0] exp_dac;
        mask_i = 2'b01; evt_tready = 1'b1;
        next_cycle();
        trig_i = 2'b11;
        sb.push_back({tb_ts, 96'h2});
        next_cycle();
        trig_i = 2'b00;
        for (int k = 0; k < 7; k++) begin
            @(negedge aclk);
            exp_dac = (k >= 1 && k <= 4) ? 128'h20 : 128'h0;
            n_total++; if (dac_tdata !== exp_dac) $display("FAIL mask_dac k=%0d got %h exp %h", k, dac_tdata, exp_dac); else n_pass++;
        end
        mask_i = 2'b00;
        idle(3);
        n_total++; if (sb.size() != 0) $display("FAIL mask_pending got %0d exp 0", sb.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] t0;
        holdoff_i = 16'd0; evt_tready = 1'b1;
        next_cycle();
        t0 = tb_ts;
        trig_i = 2'b01;
        for (int j = 0; j < 12; j++) sb.push_back({t0 + 32'(j), 96'h1});
        idle(12);
        trig_i = 2'b00;
        idle(4);
        @(negedge aclk);
        n_total++; if (overflow_count_o !== 16'd0) $display("FAIL b2b_overflow got %0d exp 0", overflow_count_o); else n_pass++;
        n_total++; if (fifo_count_o !== 5'd0) $display("FAIL b2b_count got %0d exp 0", fifo_count_o); else n_pass++;
        n_total++; if (sb.size() != 0) $display("FAIL b2b_pending got %0d exp 0", sb.size()); else n_pass++;
    endtask

    task automatic fire_beam0(input bit expect_kept);
        next_cycle();
        trig_i = 2'b01;
        if (expect_kept) sb.push_back({tb_ts, 96'h1});
        next_cycle();
        trig_i = 2'b00;
    endtask

    task automatic drain(input string tag);
        next_cycle();
        evt_tready = 1'b1;
        for (int g = 0; g < 60; g++) begin
            @(negedge aclk);
            if (fifo_count_o == 5'd0) break;
        end
        idle(2);
        n_total++; if (fifo_count_o !== 5'd0) $display("FAIL %s_drain_count got %0d exp 0", tag, fifo_count_o); else n_pass++;
        n_total++; if (sb.size() != 0) $display("FAIL %s_drain_pending got %0d exp 0", tag, sb.size()); else n_pass++;
    endtask

    task automatic test_overflow();
        evt_tready = 1'b0; holdoff_i = 16'd0;
        for (int j = 0; j < 20; j++) fire_beam0(j < 16);
        idle(3);
        @(negedge aclk);
        n_total++; if (fifo_count_o !== 5'd16) $display("FAIL ovf_count got %0d exp 16", fifo_count_o); else n_pass++;
        n_total++; if (overflow_count_o !== 16'd4) $display("FAIL ovf_dropped got %0d exp 4", overflow_count_o); else n_pass++;
        n_total++; if (evt_tvalid !== 1'b1) $display("FAIL ovf_tvalid got %b exp 1", evt_tvalid); else n_pass++;
        n_total++; if (evt_tdata !== sb[0]) $display("FAIL ovf_head got %h exp %h", evt_tdata, sb[0]); else n_pass++;
        idle(3);
        n_total++; if (evt_tdata !== sb[0]) $display("FAIL ovf_head_stable got %h exp %h", evt_tdata, sb[0]); else n_pass++;
        drain("ovf");
        n_total++; if (overflow_count_o !== 16'd4) $display("FAIL ovf_after_drain got %0d exp 4", overflow_count_o); else n_pass++;
    endtask

    task automatic test_full_pop();
        evt_tready = 1'b0;
        for (int j = 0; j < 16; j++) fire_beam0(1'b1);
        idle(2);
        @(negedge aclk);
        n_total++; if (fifo_count_o !== 5'd16) $display("FAIL fullpop_prefill got %0d exp 16", fifo_count_o); else n_pass++;
        next_cycle();
        trig_i = 2'b01;
        sb.push_back({tb_ts, 96'h1});
        next_cycle();
        trig_i = 2'b00;
        evt_tready = 1'b1;
        next_cycle();
        evt_tready = 1'b0;
        @(negedge aclk);
        n_total++; if (fifo_count_o !== 5'd16) $display("FAIL fullpop_count got %0d exp 16", fifo_count_o); else n_pass++;
        n_total++; if (overflow_count_o !== 16'd4) $display("FAIL fullpop_overflow got %0d exp 4", overflow_count_o); else n_pass++;
        drain("fullpop");
    endtask

    task automatic test_reset_mid();
        evt_tready = 1'b0;
        holdoff_i = 16'd100;
        next_cycle();
        trig_i = 2'b10;
        sb.push_back({tb_ts, 96'h2});
        next_cycle();
        trig_i = 2'b00;
        holdoff_i = 16'd0;
        for (int j = 0; j < 4; j++) fire_beam0(1'b1);
        next_cycle();
        n_total++; if (fifo_count_o !== 5'd5) $display("FAIL rmid_pre_count got %0d exp 5", fifo_count_o); else n_pass++;
        n_total++; if (dac_tdata !== 128'h10) $display("FAIL rmid_pre_dac got %h exp 10", dac_tdata); else n_pass++;
        aresetn = 1'b0;
        #1;
        n_total++; if (dac_tdata !== 128'd0) $display("FAIL rmid_dac got %h exp 0", dac_tdata); else n_pass++;
        n_total++; if (dac_tvalid !== 1'b0) $display("FAIL rmid_dac_tvalid got %b exp 0", dac_tvalid); else n_pass++;
        n_total++; if (evt_tdata !== 128'd0) $display("FAIL rmid_evt_tdata got %h exp 0", evt_tdata); else n_pass++;
        n_total++; if (evt_tvalid !== 1'b0) $display("FAIL rmid_evt_tvalid got %b exp 0", evt_tvalid); else n_pass++;
        n_total++; if (fifo_count_o !== 5'd0) $display("FAIL rmid_count got %0d exp 0", fifo_count_o); else n_pass++;
        n_total++; if (overflow_count_o !== 16'd0) $display("FAIL rmid_overflow got %0d exp 0", overflow_count_o); else n_pass++;
        sb.delete();
        next_cycle();
        aresetn = 1'b1;
        trig_i = 2'b11;
        evt_tready = 1'b1;
        sb.push_back({32'd0, 96'h3});
        #1;
        n_total++; if (evt_tvalid !== 1'b0) $display("FAIL rmid_release_tvalid got %b exp 0", evt_tvalid); else n_pass++;
        next_cycle();
        trig_i = 2'b00;
        idle(4);
        n_total++; if (sb.size() != 0) $display("FAIL rmid_restart_pending got %0d exp 0", sb.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_holdoff();
        test_mask();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
